// File: rtl/cfeb_rdout_seq_if.sv
// cfeb_rdout_seq_if: request/handshake bundle between the readout
// request logic, the CPLD clock/push control block and the sequencer.
interface cfeb_rdout_seq_if #(
  parameter int NSAMP_W = 5
);
  logic               REQ;
  logic [NSAMP_W-1:0] NSAMP;
  logic               HOLD;
  logic [5:0]         OEN_B;
  logic               XLOAD;
  logic               PUSH;
  logic               SENDCHECK;
  logic               LASTWORD;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic [NSAMP_W-1:0] SMP_CNT;

  modport master (
    output REQ,
    output NSAMP,
    output HOLD,
    output OEN_B,
    input  XLOAD,
    input  PUSH,
    input  SENDCHECK,
    input  LASTWORD,
    input  BUSY,
    input  DONE,
    input  ERR,
    input  SMP_CNT
  );

  modport slave (
    input  REQ,
    input  NSAMP,
    input  HOLD,
    input  OEN_B,
    output XLOAD,
    output PUSH,
    output SENDCHECK,
    output LASTWORD,
    output BUSY,
    output DONE,
    output ERR,
    output SMP_CNT
  );
endinterface

// File: rtl/cfeb_rdout_seq.sv
// cfeb_rdout_seq: CFEB readout sequencer (XLOAD, PUSH, SENDCHECK, LASTWORD).
// Define CFEB_RDSEQ_CHECK_EN to append the check-word frame before LASTWORD.
module cfeb_rdout_seq #(
  parameter int NSAMP_W = 5,
  parameter int NPHASE  = 6,
  parameter int WDOG    = 15
) (
  input  logic            CLK,
  input  logic            RST,
  cfeb_rdout_seq_if.slave bus
);

  localparam int WD_W = $clog2(WDOG + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG - 1);

`ifdef CFEB_RDSEQ_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_XFER, S_LAST, S_FIN, S_CHECK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_XFER, S_LAST, S_FIN
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [NSAMP_W-1:0] nreq_q, nreq_d;
  logic [NSAMP_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               xload_q, xload_d;
  logic               push_q, push_d;
  logic               lastword_q, lastword_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic            fb, ls;
  logic            wd_hit;
  logic            abort;
  logic [WD_W-1:0] wd_nxt;
  logic            unused_oen;

  // Decode uses the raw bits; a malformed OEN_B is left to the watchdog.
  assign fb         = ~bus.OEN_B[NPHASE-1];
  assign ls         = ~bus.OEN_B[0];
  assign unused_oen = ^bus.OEN_B[NPHASE-2:1];

  assign wd_hit = ~fb & (wd_q == WD_MAX);
  assign wd_nxt = fb ? '0 : wd_q + WD_W'(1);

  always_comb begin
    state_d = state_q;
    nreq_d  = nreq_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ && bus.NSAMP != '0) begin
          nreq_d  = bus.NSAMP;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d  = wd_nxt;
        abort = wd_hit;
        if (fb && !bus.HOLD) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        wd_d  = wd_nxt;
        abort = wd_hit;
        if (ls && cnt_q < nreq_q) begin
          cnt_d = cnt_q + NSAMP_W'(1);
        end
        // Frame decisions land on the boundary so PUSH covers whole frames.
        if (fb) begin
          if (cnt_q == nreq_q) begin
`ifdef CFEB_RDSEQ_CHECK_EN
            state_d = S_CHECK;
`else
            state_d = S_LAST;
`endif
          end else if (bus.HOLD) begin
            state_d = S_WAIT;
          end
        end
      end
`ifdef CFEB_RDSEQ_CHECK_EN
      S_CHECK: begin
        wd_d  = wd_nxt;
        abort = wd_hit;
        if (fb) begin
          state_d = S_LAST;
        end
      end
`endif
      S_LAST: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    xload_d    = (state_d == S_LOAD);
    lastword_d = (state_d == S_LAST);
    done_d     = (state_d == S_FIN);
    busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
    err_d      = abort | (bus.REQ & (state_q != S_IDLE));
`ifdef CFEB_RDSEQ_CHECK_EN
    push_d     = (state_d == S_XFER) || (state_d == S_CHECK);
`else
    push_d     = (state_d == S_XFER);
`endif
  end

`ifdef CFEB_RDSEQ_CHECK_EN
  logic sendcheck_q, sendcheck_d;

  assign sendcheck_d   = (state_d == S_CHECK);
  assign bus.SENDCHECK = sendcheck_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sendcheck_q <= 1'b0;
    end else begin
      sendcheck_q <= sendcheck_d;
    end
  end
`else
  assign bus.SENDCHECK = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      nreq_q     <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      xload_q    <= 1'b0;
      push_q     <= 1'b0;
      lastword_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nreq_q     <= nreq_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      xload_q    <= xload_d;
      push_q     <= push_d;
      lastword_q <= lastword_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.XLOAD    = xload_q;
  assign bus.PUSH     = push_q;
  assign bus.LASTWORD = lastword_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.SMP_CNT  = cnt_q;

endmodule

// File: tb/tb_cfeb_rdout_seq.sv
// tb_cfeb_rdout_seq: directed scoreboard bench for cfeb_rdout_seq.
// Expected per-cycle output vectors are queued at request time.
`timescale 1ns/1ps
module tb_cfeb_rdout_seq;

  localparam int NW = 5;

`ifdef CFEB_RDSEQ_CHECK_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  // {XLOAD,PUSH,SENDCHECK,LASTWORD,BUSY,DONE,ERR}
  localparam logic [6:0] F_XL = 7'b1000000;
  localparam logic [6:0] F_PU = 7'b0100000;
  localparam logic [6:0] F_SC = 7'b0010000;
  localparam logic [6:0] F_LW = 7'b0001000;
  localparam logic [6:0] F_BZ = 7'b0000100;
  localparam logic [6:0] F_DN = 7'b0000010;
  localparam logic [6:0] F_ER = 7'b0000001;

  typedef logic [6+NW:0] vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  cfeb_rdout_seq_if #(.NSAMP_W(NW)) bus ();

  cfeb_rdout_seq #(
    .NSAMP_W(NW),
    .NPHASE (6),
    .WDOG   (15)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #12.5 CLK = ~CLK;

  vec_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    ph    = 5;
  bit    rot   = 1'b1;
  string tname = "init";

  function automatic vec_t mk(input logic [6:0] f, input int c);
    return {f, NW'(c)};
  endfunction

  function automatic vec_t obs();
    return {bus.XLOAD, bus.PUSH, bus.SENDCHECK, bus.LASTWORD,
            bus.BUSY, bus.DONE, bus.ERR, bus.SMP_CNT};
  endfunction

  task automatic chk(input string tag, input vec_t o, input vec_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // One clock: compare the queued vector, then advance the OEN_B rotation.
  task automatic step(input int k);
    vec_t e;
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s k=%0d", tname, k), obs(), e);
    end
    ph = (ph + 1) % 6;
    bus.OEN_B = rot ? ~(6'b100000 >> ph) : 6'b111111;
  endtask

  task automatic align();
    while (ph != 0) step(-1);
  endtask

  task automatic add_txn(input int n, input int hf, output int dk);
    int c;
    c = 0;
    exp_q.push_back(mk(F_XL | F_BZ, 0));
    repeat (5) exp_q.push_back(mk(F_BZ, 0));
    for (int f = 1; f <= n; f++) begin
      for (int p = 0; p < 6; p++) begin
        if (p == 5) c = f;
        exp_q.push_back(mk(F_PU | F_BZ, c));
      end
      if (f == hf) repeat (6) exp_q.push_back(mk(F_BZ, c));
    end
    if (CE) repeat (6) exp_q.push_back(mk(F_PU | F_SC | F_BZ, n));
    exp_q.push_back(mk(F_LW | F_BZ, n));
    exp_q.push_back(mk(F_DN, n));
    dk = exp_q.size() - 1;
  endtask

  task automatic run_txn(input int n, input int r2k, input int n2,
                         input int hlo, input int hhi);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      bus.REQ   = (k == 0) || (k == r2k);
      bus.NSAMP = (k == 0) ? NW'(n) : NW'(n2);
      bus.HOLD  = (k >= hlo) && (k < hhi);
      step(k);
      k++;
    end
    bus.REQ  = 1'b0;
    bus.HOLD = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    int dk;
    bus.REQ   = 1'b0;
    bus.NSAMP = '0;
    bus.HOLD  = 1'b0;
    bus.OEN_B = 6'b111111;
    repeat (2) @(posedge CLK);
    #1;
    tname = "reset";
    chk(tname, obs(), mk(7'b0, 0));
    RST = 1'b0;

    tname = "basic";
    align();
    add_txn(3, 0, dk);
    exp_q.push_back(mk(F_ER, 3));
    repeat (2) exp_q.push_back(mk(7'b0, 3));
    run_txn(3, dk + 1, 1, -1, -1);

    tname = "nsamp0";
    align();
    repeat (4) exp_q.push_back(mk(7'b0, 3));
    run_txn(0, -1, 0, -1, -1);

    tname = "hold";
    align();
    add_txn(4, 1, dk);
    repeat (2) exp_q.push_back(mk(7'b0, 4));
    run_txn(4, -1, 0, 12, 18);

    tname = "wdog";
    rot = 1'b0;
    bus.OEN_B = 6'b111111;
    exp_q.push_back(mk(F_XL | F_BZ, 0));
    repeat (15) exp_q.push_back(mk(F_BZ, 0));
    exp_q.push_back(mk(F_ER, 0));
    repeat (2) exp_q.push_back(mk(7'b0, 0));
    run_txn(2, -1, 0, -1, -1);
    rot = 1'b1;

    tname = "overlap";
    align();
    add_txn(2, 0, dk);
    exp_q[8] = exp_q[8] | mk(F_ER, 0);
    repeat (2) exp_q.push_back(mk(7'b0, 2));
    run_txn(2, 8, 5, -1, -1);

    tname = "rst_mid";
    align();
    add_txn(1, 0, dk);
    for (int k = 0; k < (CE ? 14 : 8); k++) begin
      bus.REQ   = (k == 0);
      bus.NSAMP = NW'(1);
      step(k);
    end
    bus.REQ = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_async", obs(), mk(7'b0, 0));
    exp_q.delete();
    #1;
    RST = 1'b0;
    tname = "post_rst";
    repeat (8) exp_q.push_back(mk(7'b0, 0));
    while (exp_q.size() > 0) step(-2);

    tname = "after_rst";
    align();
    add_txn(1, 0, dk);
    repeat (2) exp_q.push_back(mk(7'b0, 1));
    run_txn(1, -1, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
